aes_key_expander: RTL and testbench

// - Sequential AES-128 key expansion stage. Sits directly upstream of the round datapath and drives the existing key_schedule stage.
// - Accepts a cipher key via valid/ready and produces round keys 1..NUM_ROUNDS, one per clock, by iterating key_schedule.
// - Stores all NUM_ROUNDS+1 round keys in a register file that the round controller reads by round number.

---
 rtl/aes_key_expander_pkg.sv | 85 ++++++++
 rtl/aes_key_expander_key_schedule.sv | 49 ++++
 rtl/aes_key_expander.sv | 120 ++++++++++++
 tb/tb_aes_key_expander.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expander_pkg.sv
// Shared AES definitions: sizes, small typedefs, FSM encoding and the GF(2^8)
// helpers used by the key schedule.
package aes_key_expander_pkg;

    localparam int KEY_SIZE      = 128;
    localparam int DATA_SIZE     = 128;
    localparam int AES128_ROUNDS = 10;

    typedef logic [31:0] u32;
    typedef logic [7:0]  u8;
    typedef logic [3:0]  u4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    function automatic u8 xtime(input u8 a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic u8 gf_mul(input u8 a, input u8 b);
        u8 p;
        u8 x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via a short addition chain; 0 maps to 0.
    function automatic u8 gf_inv(input u8 a);
        u8 x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic u8 sbox(input u8 a);
        u8 b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic u32 sub_word(input u32 w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte 0 of a word sits in the most significant position.
    function automatic u32 rot_word(input u32 w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic u8 rcon(input u4 round_index);
        u8 rc;
        case (round_index)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_expander_key_schedule.sv
// Single AES-128 key schedule step: round key r-1 -> r (encrypt) or r -> r-1
// (decrypt). Purely combinational.
module key_schedule
    import aes_key_expander_pkg::*;
#(
    parameter int KEY_W = KEY_SIZE
) (
    input  logic [KEY_W-1:0] key_in,
    input  logic             encrypt,
    input  u4                round_index,
    output logic [KEY_W-1:0] key_out
);

    function automatic u32 function_g(input u32 w, input u4 r);
        return sub_word(rot_word(w)) ^ {rcon(r), 24'h000000};
    endfunction

    u32 w0, w1, w2, w3;
    u32 n0, n1, n2, n3;

    assign w0 = key_in[31:0];
    assign w1 = key_in[63:32];
    assign w2 = key_in[95:64];
    assign w3 = key_in[127:96];

    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a value held, which would infer a latch.
    always_comb begin
        n0 = '0;
        n1 = '0;
        n2 = '0;
        n3 = '0;
        if (encrypt) begin
            n0 = w0 ^ function_g(w3, round_index);
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end else begin
            // Undo the chained XORs, then recover word 0 from the rebuilt word 3.
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ function_g(n3, round_index);
        end
    end

    assign key_out = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expander: accepts a cipher key, iterates key_schedule
// once per clock and holds round keys 0..NUM_ROUNDS in a readable register file.
module aes_key_expander
    import aes_key_expander_pkg::*;
#(
    parameter int KEY_W      = KEY_SIZE,
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out
);

    localparam u4 LAST_ROUND = u4'(NUM_ROUNDS);

    state_t           state;
    u4                cnt;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] ks_out;
    logic             accept;

    logic             wr_en;
    u4                wr_idx;
    logic [KEY_W-1:0] wr_data;
    logic [KEY_W-1:0] rk_mem [0:NUM_ROUNDS];

    assign accept = key_valid && key_ready;

    key_schedule #(
        .KEY_W(KEY_W)
    ) u_key_schedule (
        .key_in      (work),
        .encrypt     (1'b1),
        .round_index (cnt),
        .key_out     (ks_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            work       <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        state      <= ST_EXPAND;
                        work       <= key_in;
                        cnt        <= 4'd1;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    work <= ks_out;
                    if (cnt == LAST_ROUND) begin
                        state      <= ST_READY;
                        cnt        <= '0;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    keys_valid <= 1'b0;
                end
            endcase
        end
    end

    // Single write port: the accept edge loads slot 0, each expand edge loads slot cnt.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cnt;
        wr_data = ks_out;
        if (accept) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = key_in;
        end else if (state == ST_EXPAND) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the key store has no reset; keys_valid alone qualifies its
    // contents, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) rk_mem[wr_idx] <= wr_data;
    end

    // Registered read with no write bypass: a same-edge write is seen next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out <= '0;
        end else if (rk_idx <= LAST_ROUND) begin
            rk_out <= rk_mem[rk_idx];
        end else begin
            rk_out <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors plus random keys
// compared against a word-level key expansion model.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    localparam logic [127:0] KEY_A1  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [127:0] A1_RK1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
    localparam logic [127:0] A1_RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] Z_RK10  = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   sbox_t   [256];
    logic [127:0] rk_model [11];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // FIPS-197 KeyExpansion over a flat 44-word array.
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                     ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Runs until keys_valid (bounded); optionally pulses a foreign key in EXPAND cycles 3..7.
    task automatic wait_ready(input bit noise, input logic [127:0] noise_key,
                              output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!keys_valid && cyc < 30) begin
            if (busy) busy_cyc++;
            key_valid = noise && (cyc + 1 >= 3) && (cyc + 1 <= 7);
            if (noise) key_in = noise_key;
            tick();
            cyc++;
        end
        key_valid = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 11; i++) begin
            rk_idx = 4'(i);
            tick();
            check($sformatf("%s rk%0d", tag, i), rk_out, rk_model[i]);
        end
        rk_idx = 4'd11;
        tick();
        check($sformatf("%s idx11", tag), rk_out, 128'd0);
        rk_idx = 4'd15;
        tick();
        check($sformatf("%s idx15", tag), rk_out, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           cyc;
        int           bc;
        logic [127:0] k;
        logic [127:0] old5;
        logic [127:0] old10;

        build_sbox();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_idx    = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset key_ready", 128'(key_ready), 128'd1);
        check("reset busy", 128'(busy), 128'd0);
        check("reset keys_valid", 128'(keys_valid), 128'd0);
        check("reset rk_out", rk_out, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // FIPS-197 A.1 key
        compute_model(KEY_A1);
        accept(KEY_A1);
        check("a1 busy after accept", 128'(busy), 128'd1);
        check("a1 key_ready after accept", 128'(key_ready), 128'd0);
        wait_ready(1'b0, '0, cyc, bc);
        check("a1 latency", 128'(cyc), 128'd10);
        check("a1 busy cycles", 128'(bc), 128'd10);
        check("a1 busy done", 128'(busy), 128'd0);
        check("a1 key_ready done", 128'(key_ready), 128'd1);
        rk_idx = 4'd1;
        tick();
        check("a1 fips rk1", rk_out, A1_RK1);
        rk_idx = 4'd10;
        tick();
        check("a1 fips rk10", rk_out, A1_RK10);
        read_all("a1");

        // Random keys; the first one has a foreign key pulsed while expanding.
        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            compute_model(k);
            accept(k);
            wait_ready(t == 0, ~k, cyc, bc);
            check($sformatf("rand%0d latency", t), 128'(cyc), 128'd10);
            read_all($sformatf("rand%0d", t));
        end

        // Rekey from READY with the all-zero key; old contents visible until overwritten.
        old5  = rk_model[5];
        old10 = rk_model[10];
        compute_model(128'd0);
        rk_idx = 4'd5;
        accept(128'd0);
        check("rekey keys_valid low", 128'(keys_valid), 128'd0);
        check("rekey old rk5", rk_out, old5);
        rk_idx = 4'd10;
        tick();
        check("rekey old rk10", rk_out, old10);
        wait_ready(1'b0, '0, cyc, bc);
        check("rekey latency", 128'(cyc + 1), 128'd10);
        rk_idx = 4'd10;
        tick();
        check("zero fips rk10", rk_out, Z_RK10);
        read_all("zero");

        // Asynchronous reset in the middle of expansion (cnt = 6).
        compute_model(KEY_A1);
        accept(KEY_A1);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset keys_valid", 128'(keys_valid), 128'd0);
        check("midreset busy", 128'(busy), 128'd0);
        check("midreset key_ready", 128'(key_ready), 128'd1);
        check("midreset rk_out", rk_out, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        accept(KEY_A1);
        wait_ready(1'b0, '0, cyc, bc);
        check("post-reset latency", 128'(cyc), 128'd10);
        rk_idx = 4'd10;
        tick();
        check("post-reset fips rk10", rk_out, A1_RK10);
        read_all("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
